// File: rtl/hls_fp32_mul_core_chn_a_rsci_wait_ctrl_dp_if.sv
// chn_a operand channel: upstream vld/rdy/data plus the core-side read/consume controls.
// master = upstream source and core driver; slave = wait-control datapath.
interface hls_fp32_mul_core_chn_a_rsci_wait_ctrl_dp_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
);
  logic             chn_a_vld;
  logic [WIDTH-1:0] chn_a_data;
  logic             chn_a_rdy;
  logic             chn_a_rsci_iswt0;
  logic             chn_a_rsci_oswt;
  logic             chn_a_rsci_ld_core_psct;
  logic             core_wen;
  logic             core_wten;
  logic [WIDTH-1:0] chn_a_rsci_d_mxwt;
  logic             chn_a_rsci_bawt;
  logic             chn_a_rsci_wen_comp;
  logic [CNTW-1:0]  chn_a_xfer_cnt;

  modport master (
    output chn_a_vld, chn_a_data, chn_a_rsci_iswt0, chn_a_rsci_oswt,
           chn_a_rsci_ld_core_psct, core_wen, core_wten,
    input  chn_a_rdy, chn_a_rsci_d_mxwt, chn_a_rsci_bawt, chn_a_rsci_wen_comp,
           chn_a_xfer_cnt
  );

  modport slave (
    input  chn_a_vld, chn_a_data, chn_a_rsci_iswt0, chn_a_rsci_oswt,
           chn_a_rsci_ld_core_psct, core_wen, core_wten,
    output chn_a_rdy, chn_a_rsci_d_mxwt, chn_a_rsci_bawt, chn_a_rsci_wen_comp,
           chn_a_xfer_cnt
  );
endinterface

// File: rtl/hls_fp32_mul_core_chn_a_rsci_wait_ctrl_dp.sv
// chn_a receive wait control: zero-latency bypass to the core, else a one-entry hold buffer.
// rdy only while a core read is outstanding; a buffered word is held until the core consumes it.
module hls_fp32_mul_core_chn_a_rsci_wait_ctrl_dp #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rst,
  hls_fp32_mul_core_chn_a_rsci_wait_ctrl_dp_if.slave chn
);

  logic             icwt_q, icwt_d;
  logic             bcwt_q, bcwt_d;
  logic [WIDTH-1:0] d_bfwt_q, d_bfwt_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic pdswt0, ogwt, rdy, biwt, bdwt, bawt;

  always_comb begin
    pdswt0   = chn.chn_a_rsci_iswt0 & ~chn.core_wten;
    ogwt     = pdswt0 | icwt_q;
    rdy      = chn.chn_a_rsci_ld_core_psct & ogwt;
    biwt     = rdy & chn.chn_a_vld;
    bdwt     = chn.chn_a_rsci_oswt & chn.core_wen;
    bawt     = biwt | bcwt_q;

    // An unsatisfied read stays pending across stalls, so no re-issue is needed.
    icwt_d   = ogwt & ~biwt;
    bcwt_d   = (bcwt_q | biwt) & ~bdwt;
    d_bfwt_d = d_bfwt_q;
    cnt_d    = cnt_q;
    if (biwt) begin
      d_bfwt_d = chn.chn_a_data;
      cnt_d    = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      icwt_q   <= 1'b0;
      bcwt_q   <= 1'b0;
      d_bfwt_q <= '0;
      cnt_q    <= '0;
    end else begin
      icwt_q   <= icwt_d;
      bcwt_q   <= bcwt_d;
      d_bfwt_q <= d_bfwt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign chn.chn_a_rdy           = rdy;
  assign chn.chn_a_rsci_bawt     = bawt;
  assign chn.chn_a_rsci_d_mxwt   = bcwt_q ? d_bfwt_q : chn.chn_a_data;
  assign chn.chn_a_rsci_wen_comp = ~chn.chn_a_rsci_oswt | bawt;
  assign chn.chn_a_xfer_cnt      = cnt_q;

endmodule

// File: tb/tb_hls_fp32_mul_core_chn_a_rsci_wait_ctrl_dp.sv
// Directed bench for the chn_a wait control with a narrow counter to exercise wrap.
module tb_hls_fp32_mul_core_chn_a_rsci_wait_ctrl_dp;
  localparam int WIDTH = 32;
  localparam int CNTW  = 4;

  logic clk;
  logic rst;
  int   vectors    = 0;
  int   miscompares = 0;
  int   proto_err  = 0;

  hls_fp32_mul_core_chn_a_rsci_wait_ctrl_dp_if #(.WIDTH(WIDTH), .CNTW(CNTW)) chn ();

  hls_fp32_mul_core_chn_a_rsci_wait_ctrl_dp #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .chn            (chn.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A buffered word must be consumed before the core issues another read.
  always @(negedge clk) begin
    if (!rst && chn.chn_a_rsci_iswt0 && !chn.core_wten && chn.chn_a_rsci_bawt
        && !(chn.chn_a_rdy && chn.chn_a_vld))
      proto_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iswt0, input logic wten, input logic vld,
                       input logic [31:0] data, input logic oswt, input logic wen);
    chn.chn_a_rsci_iswt0 = iswt0;
    chn.core_wten        = wten;
    chn.chn_a_vld        = vld;
    chn.chn_a_data       = data;
    chn.chn_a_rsci_oswt  = oswt;
    chn.core_wen         = wen;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    chn.chn_a_rsci_ld_core_psct = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1);
    tick();
    tick();

    // reset state
    chk("rst_rdy",  32'(chn.chn_a_rdy), 32'd0);
    chk("rst_bawt", 32'(chn.chn_a_rsci_bawt), 32'd0);
    chk("rst_wenc", 32'(chn.chn_a_rsci_wen_comp), 32'd1);
    chk("rst_cnt",  32'(chn.chn_a_xfer_cnt), 32'd0);
    chk("rst_mx",   chn.chn_a_rsci_d_mxwt, 32'h12345678);
    rst = 1'b0;

    // same-cycle handshake and consume: bypass
    drive(1'b1, 1'b0, 1'b1, 32'h3F800000, 1'b1, 1'b1);
    chk("byp_rdy",  32'(chn.chn_a_rdy), 32'd1);
    chk("byp_bawt", 32'(chn.chn_a_rsci_bawt), 32'd1);
    chk("byp_mx",   chn.chn_a_rsci_d_mxwt, 32'h3F800000);
    chk("byp_wenc", 32'(chn.chn_a_rsci_wen_comp), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("byp_bcwt0", 32'(chn.chn_a_rsci_bawt), 32'd0);
    chk("byp_rdy0",  32'(chn.chn_a_rdy), 32'd0);
    chk("byp_cnt",   32'(chn.chn_a_xfer_cnt), 32'd1);

    // pending read held across a stall
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("pend_c1_rdy", 32'(chn.chn_a_rdy), 32'd1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("pend_c2_rdy",  32'(chn.chn_a_rdy), 32'd1);
    chk("pend_c2_wenc", 32'(chn.chn_a_rsci_wen_comp), 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("pend_c3_rdy", 32'(chn.chn_a_rdy), 32'd1);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h40000000, 1'b0, 1'b0);
    chk("pend_c4_rdy",  32'(chn.chn_a_rdy), 32'd1);
    chk("pend_c4_bawt", 32'(chn.chn_a_rsci_bawt), 32'd1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("pend_c5_rdy",  32'(chn.chn_a_rdy), 32'd0);
    chk("pend_c5_bawt", 32'(chn.chn_a_rsci_bawt), 32'd1);
    chk("pend_c5_mx",   chn.chn_a_rsci_d_mxwt, 32'h40000000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("pend_c6_bawt", 32'(chn.chn_a_rsci_bawt), 32'd0);
    chk("pend_cnt",     32'(chn.chn_a_xfer_cnt), 32'd2);

    // handshake into a stalled core: word held while upstream data changes
    drive(1'b1, 1'b0, 1'b1, 32'hC0490FDB, 1'b1, 1'b0);
    chk("hold_c1_mx", chn.chn_a_rsci_d_mxwt, 32'hC0490FDB);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
      chk("hold_bawt", 32'(chn.chn_a_rsci_bawt), 32'd1);
      chk("hold_mx",   chn.chn_a_rsci_d_mxwt, 32'hC0490FDB);
      chk("hold_rdy",  32'(chn.chn_a_rdy), 32'd0);
      chk("hold_wenc", 32'(chn.chn_a_rsci_wen_comp), 32'd1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
    chk("hold_take_bawt", 32'(chn.chn_a_rsci_bawt), 32'd1);
    chk("hold_take_mx",   chn.chn_a_rsci_d_mxwt, 32'hC0490FDB);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("hold_done_bawt", 32'(chn.chn_a_rsci_bawt), 32'd0);
    chk("hold_done_mx",   chn.chn_a_rsci_d_mxwt, 32'h0);
    chk("hold_cnt",       32'(chn.chn_a_xfer_cnt), 32'd3);

    // reset discards a buffered word
    drive(1'b1, 1'b0, 1'b1, 32'hAAAA5555, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b0);
    chk("buf_bawt", 32'(chn.chn_a_rsci_bawt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b0);
    chk("rstbuf_bawt", 32'(chn.chn_a_rsci_bawt), 32'd0);
    chk("rstbuf_mx",   chn.chn_a_rsci_d_mxwt, 32'h11111111);
    chk("rstbuf_cnt",  32'(chn.chn_a_xfer_cnt), 32'd0);

    // reset discards a pending read
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("icwt_rdy", 32'(chn.chn_a_rdy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    chk("rsticwt_rdy", 32'(chn.chn_a_rdy), 32'd0);
    tick();
    chk("rsticwt_cnt", 32'(chn.chn_a_xfer_cnt), 32'd0);

    // 17 back-to-back handshakes wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'(i) * 32'h01010101, 1'b1, 1'b1);
      chk("b2b_mx", chn.chn_a_rsci_d_mxwt, 32'(i) * 32'h01010101);
      if (i == 16) chk("b2b_cnt16", 32'(chn.chn_a_xfer_cnt), 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("b2b_wrap", 32'(chn.chn_a_xfer_cnt), 32'd1);
    chk("b2b_bawt", 32'(chn.chn_a_rsci_bawt), 32'd0);

    chk("protocol", 32'(proto_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
